// File: rtl/axis_round_robin_merge.sv
// axis_round_robin_merge
// Merges NUM_SLAVE_STREAMS AXI-stream inputs onto one output, one whole packet at a time.
// Inputs are granted in round-robin order starting after the last stream to finish a packet.
// Arbitration takes one IDLE cycle per packet, then stream `sel` passes straight through
// combinationally until its tlast beat is accepted. axis_o_tid carries the granted index.

module axis_round_robin_merge #(
    parameter int AXIS_BYTES        = 1,
    parameter int NUM_SLAVE_STREAMS = 2
) (
    input  logic                                      clk,
    input  logic                                      sreset,

    output logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tready,
    input  logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tvalid,
    input  logic [NUM_SLAVE_STREAMS-1:0]              axis_i_tlast,
    input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,

    input  logic                                      axis_o_tready,
    output logic                                      axis_o_tvalid,
    output logic                                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]                   axis_o_tdata,
    output logic [$clog2(NUM_SLAVE_STREAMS)-1:0]      axis_o_tid
);

    localparam int W    = AXIS_BYTES * 8;
    localparam int N    = NUM_SLAVE_STREAMS;
    localparam int IdxW = $clog2(N);

    // Highest legal index; the round-robin increment wraps here, so N need not be a power of 2.
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if (N < 2) begin : g_param_check
        $error("NUM_SLAVE_STREAMS must be at least 2");
    end

    typedef enum logic {
        StIdle,
        StPass
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic [IdxW-1:0]   last_sel_q, last_sel_d;

    // Round-robin search results
    logic              found;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   pick;

    // Selected-stream view
    logic              sel_valid;
    logic              sel_last;
    logic [W-1:0]      sel_data;

    // Search last_sel+1, last_sel+2, ... (mod N) for the first valid input.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = last_sel_q;
        for (int i = 0; i < N; i++) begin
            cand = (cand == LastIdx) ? '0 : cand + 1'b1;
            if (!found && axis_i_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Mux the granted stream's valid/last/data.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int n = 0; n < N; n++) begin
            if (sel_q == IdxW'(n)) begin
                sel_valid = axis_i_tvalid[n];
                sel_last  = axis_i_tlast[n];
                sel_data  = axis_i_tdata[n*W +: W];
            end
        end
    end

    // Next-state and output decode; outputs are all zero while arbitrating.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_sel_d    = last_sel_q;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = '0;
        axis_o_tid    = '0;
        axis_i_tready = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = StPass;
                end
            end

            StPass: begin
                axis_o_tvalid = sel_valid;
                axis_o_tlast  = sel_last;
                axis_o_tdata  = sel_data;
                axis_o_tid    = sel_q;
                // Only the granted input sees tready; the rest are held off for the whole packet.
                for (int n = 0; n < N; n++) begin
                    axis_i_tready[n] = axis_o_tready && (sel_q == IdxW'(n));
                end
                if (sel_valid && sel_last && axis_o_tready) begin
                    state_d    = StIdle;
                    last_sel_d = sel_q;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight and gives stream 0 first priority.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            last_sel_q <= LastIdx;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

endmodule

// File: tb/tb_axis_round_robin_merge.sv
// Directed bench for axis_round_robin_merge: a 2-input instance driven from per-stream beat
// queues, and a 3-input instance with every input permanently offering single-beat packets.

module tb_axis_round_robin_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-stream instance
    logic        sreset;
    logic [1:0]  i_tready, i_tvalid, i_tlast;
    logic [15:0] i_tdata;
    logic        o_tready, o_tvalid, o_tlast;
    logic [7:0]  o_tdata;
    logic        o_tid;

    // 3-stream instance
    logic        sreset3;
    logic [2:0]  i_tready3, i_tvalid3, i_tlast3;
    logic [23:0] i_tdata3;
    logic        o_tready3, o_tvalid3, o_tlast3;
    logic [7:0]  o_tdata3;
    logic [1:0]  o_tid3;

    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_SLAVE_STREAMS(2)) dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (i_tready),
        .axis_i_tvalid (i_tvalid),
        .axis_i_tlast  (i_tlast),
        .axis_i_tdata  (i_tdata),
        .axis_o_tready (o_tready),
        .axis_o_tvalid (o_tvalid),
        .axis_o_tlast  (o_tlast),
        .axis_o_tdata  (o_tdata),
        .axis_o_tid    (o_tid)
    );

    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_SLAVE_STREAMS(3)) dut3 (
        .clk           (clk),
        .sreset        (sreset3),
        .axis_i_tready (i_tready3),
        .axis_i_tvalid (i_tvalid3),
        .axis_i_tlast  (i_tlast3),
        .axis_i_tdata  (i_tdata3),
        .axis_o_tready (o_tready3),
        .axis_o_tvalid (o_tvalid3),
        .axis_o_tlast  (o_tlast3),
        .axis_o_tdata  (o_tdata3),
        .axis_o_tid    (o_tid3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Source beat queues, entries are {tlast, tdata}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] hs = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One clock: retire beats accepted at the edge, present queue heads, settle before checks.
    task automatic cyc(input logic rdy);
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        o_tready = rdy;
        i_tvalid = 2'b00;
        i_tlast  = 2'b00;
        i_tdata  = '0;
        if (q0.size() > 0) begin
            i_tvalid[0]    = 1'b1;
            i_tlast[0]     = q0[0][8];
            i_tdata[7:0]   = q0[0][7:0];
        end
        if (q1.size() > 0) begin
            i_tvalid[1]    = 1'b1;
            i_tlast[1]     = q1[0][8];
            i_tdata[15:8]  = q1[0][7:0];
        end
        #3;
        hs = i_tvalid & i_tready;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".tvalid"}, 32'(o_tvalid), 32'd0);
        check({tag, ".tready"}, 32'(i_tready), 32'd0);
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] data, input logic tid,
                               input logic last, input logic [1:0] rdy);
        check({tag, ".tvalid"}, 32'(o_tvalid), 32'd1);
        check({tag, ".tdata"},  32'(o_tdata),  32'(data));
        check({tag, ".tid"},    32'(o_tid),    32'(tid));
        check({tag, ".tlast"},  32'(o_tlast),  32'(last));
        check({tag, ".tready"}, 32'(i_tready), 32'(rdy));
    endtask

    initial begin
        sreset    = 1'b1;
        o_tready  = 1'b1;
        i_tvalid  = '0;
        i_tlast   = '0;
        i_tdata   = '0;
        sreset3   = 1'b1;
        o_tready3 = 1'b1;
        i_tvalid3 = 3'b111;
        i_tlast3  = 3'b111;
        i_tdata3  = {8'h02, 8'h01, 8'h00};

        // Reset held with nothing valid
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1);
            expect_idle("rst");
            check("rst.tid", 32'(o_tid), 32'd0);
        end
        sreset = 1'b0;

        // Single 3-beat packet on stream 1
        q1.push_back({1'b0, 8'hA1});
        q1.push_back({1'b0, 8'hA2});
        q1.push_back({1'b1, 8'hA3});
        cyc(1'b1); expect_idle("single.arb");
        cyc(1'b1); expect_beat("single.b0", 8'hA1, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("single.b1", 8'hA2, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("single.b2", 8'hA3, 1'b1, 1'b1, 2'b10);
        cyc(1'b1); expect_idle("single.end");

        // Contention: both streams always valid, 2-beat packets, order 0,1,0,1
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b1, 8'h02});
        q0.push_back({1'b0, 8'h03}); q0.push_back({1'b1, 8'h04});
        q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h12});
        q1.push_back({1'b0, 8'h13}); q1.push_back({1'b1, 8'h14});
        cyc(1'b1); expect_idle("cont.arb0");
        cyc(1'b1); expect_beat("cont.p0b0", 8'h01, 1'b0, 1'b0, 2'b01);
        cyc(1'b1); expect_beat("cont.p0b1", 8'h02, 1'b0, 1'b1, 2'b01);
        cyc(1'b1); expect_idle("cont.arb1");
        cyc(1'b1); expect_beat("cont.p1b0", 8'h11, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("cont.p1b1", 8'h12, 1'b1, 1'b1, 2'b10);
        cyc(1'b1); expect_idle("cont.arb2");
        cyc(1'b1); expect_beat("cont.p2b0", 8'h03, 1'b0, 1'b0, 2'b01);
        cyc(1'b1); expect_beat("cont.p2b1", 8'h04, 1'b0, 1'b1, 2'b01);
        cyc(1'b1); expect_idle("cont.arb3");
        cyc(1'b1); expect_beat("cont.p3b0", 8'h13, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("cont.p3b1", 8'h14, 1'b1, 1'b1, 2'b10);
        cyc(1'b1); expect_idle("cont.end");

        // Backpressure mid-packet on stream 0 with stream 1 waiting
        q0.push_back({1'b0, 8'h21}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h23});
        q1.push_back({1'b1, 8'h31});
        cyc(1'b1); expect_idle("bp.arb0");
        cyc(1'b1); expect_beat("bp.b0", 8'h21, 1'b0, 1'b0, 2'b01);
        cyc(1'b0); expect_beat("bp.stall0", 8'h22, 1'b0, 1'b0, 2'b00);
        cyc(1'b0); expect_beat("bp.stall1", 8'h22, 1'b0, 1'b0, 2'b00);
        cyc(1'b1); expect_beat("bp.b1", 8'h22, 1'b0, 1'b0, 2'b01);
        cyc(1'b1); expect_beat("bp.b2", 8'h23, 1'b0, 1'b1, 2'b01);
        cyc(1'b1); expect_idle("bp.arb1");
        cyc(1'b1); expect_beat("bp.s1", 8'h31, 1'b1, 1'b1, 2'b10);
        cyc(1'b1); expect_idle("bp.end");

        // Reset after beat 2 of a 4-beat packet on stream 1
        q1.push_back({1'b0, 8'h41}); q1.push_back({1'b0, 8'h42});
        q1.push_back({1'b0, 8'h43}); q1.push_back({1'b1, 8'h44});
        cyc(1'b1); expect_idle("rmid.arb");
        cyc(1'b1); expect_beat("rmid.b0", 8'h41, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("rmid.b1", 8'h42, 1'b1, 1'b0, 2'b10);
        sreset = 1'b1;
        q0.push_back({1'b1, 8'h51});
        cyc(1'b1); expect_idle("rmid.rst");
        check("rmid.rst.tlast", 32'(o_tlast), 32'd0);
        sreset = 1'b0;
        cyc(1'b1); expect_beat("rmid.s0first", 8'h51, 1'b0, 1'b1, 2'b01);
        cyc(1'b1); expect_idle("rmid.arb1");
        cyc(1'b1); expect_beat("rmid.s1b2", 8'h43, 1'b1, 1'b0, 2'b10);
        cyc(1'b1); expect_beat("rmid.s1b3", 8'h44, 1'b1, 1'b1, 2'b10);
        cyc(1'b1); expect_idle("rmid.end");

        // Three streams, single-beat packets: tid 0,1,2,0,1,2 with a beat every other cycle
        @(posedge clk);
        #4;
        sreset3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #4;
            if (k % 2 == 0) begin
                check("n3.tvalid", 32'(o_tvalid3), 32'd1);
                check("n3.tid",    32'(o_tid3),    32'((k / 2) % 3));
                check("n3.tdata",  32'(o_tdata3),  32'((k / 2) % 3));
                check("n3.tlast",  32'(o_tlast3),  32'd1);
            end else begin
                check("n3.idle",   32'(o_tvalid3), 32'd0);
                check("n3.tready", 32'(i_tready3), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
